// File: rtl/sobel_timing_ctrl.sv
// Timing controller for the 3x3 Sobel pipeline: line-width measurement, lock FSM, line-delay config and pixel coordinates.
// Optional BORDER_MASK_EN restricts win_valid to pixels with a full 3x3 neighbourhood (x_pos >= 2, y_pos >= 2).
module sobel_timing_ctrl #(
   parameter int W_BITS      = 11,
   parameter int DL_OFFSET   = 3,
   parameter int MIN_W       = 8,
   parameter int LOCK_FRAMES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              de,
   input  logic              hsync,
   input  logic              vsync,
   output logic [W_BITS-1:0] h_size,
   output logic              ce,
   output logic              locked,
   output logic              frame_err,
   output logic [W_BITS-1:0] line_width,
   output logic [W_BITS-1:0] x_pos,
   output logic [W_BITS-1:0] y_pos,
   output logic              win_valid
);

   localparam int MC_W = $clog2(LOCK_FRAMES + 1);
   localparam logic [W_BITS-1:0] X_MAX    = {W_BITS{1'b1}};
   localparam logic [W_BITS-1:0] MIN_W_V  = W_BITS'(MIN_W);
   localparam logic [W_BITS-1:0] DL_OFF_V = W_BITS'(DL_OFFSET);
   localparam logic [MC_W-1:0]   LOCK_V   = MC_W'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2,
      ERR     = 2'd3
   } state_t;

   function automatic logic [W_BITS-1:0] sat_inc(input logic [W_BITS-1:0] v);
      sat_inc = (v == X_MAX) ? v : v + W_BITS'(1);
   endfunction

   logic [1:0]        rst_sync_r;
   logic              rst_int_n;
   logic              de_d1_r, de_d2_r, vs_d1_r, vs_d2_r;
   logic [W_BITS-1:0] x_cnt_r;
   logic              fr_has_r, fr_bad_r;
   logic [W_BITS-1:0] fr_w_r;
   logic              fr_has_e, fr_bad_e;
   logic [W_BITS-1:0] fr_w_e;
   logic [MC_W-1:0]   match_r, match_nxt;
   logic [W_BITS-1:0] cand_r, cand_nxt;
   state_t            state_r, state_nxt;
   logic              de_fall_s, vs_rise_s, line_acc_s, line_sat_s;
   logic              err_s, lock_nxt, h_load_s, win_nxt;
   logic [W_BITS-1:0] x_nxt, y_nxt;
   logic              unused_hsync;

   assign unused_hsync = hsync;

   // Reset synchronizer: asserts asynchronously, releases on the clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end
   assign rst_int_n = rst_sync_r[1];

   assign de_fall_s  = de_d2_r & ~de_d1_r;
   assign vs_rise_s  = vs_d1_r & ~vs_d2_r;
   assign line_acc_s = de_fall_s & (x_cnt_r >= MIN_W_V);
   assign line_sat_s = (x_cnt_r == X_MAX);

   // Fold a finishing line into the current frame before any frame-start decision
   always_comb begin
      fr_has_e = fr_has_r;
      fr_bad_e = fr_bad_r;
      fr_w_e   = fr_w_r;
      if (line_acc_s) begin
         if (line_sat_s) begin
            fr_bad_e = 1'b1;
         end else if (!fr_has_r) begin
            fr_has_e = 1'b1;
            fr_w_e   = x_cnt_r;
         end else if (x_cnt_r != fr_w_r) begin
            fr_bad_e = 1'b1;
         end else begin
            fr_bad_e = fr_bad_r;
         end
      end else begin
         fr_has_e = fr_has_r;
      end
   end

   // Lock FSM next state, match counter and candidate width
   always_comb begin
      state_nxt = state_r;
      match_nxt = match_r;
      cand_nxt  = cand_r;
      err_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (vs_rise_s) state_nxt = MEASURE;
            else           state_nxt = IDLE;
         end
         MEASURE: begin
            if (vs_rise_s) begin
               if (fr_has_e && !fr_bad_e && (fr_w_e == cand_r)) begin
                  match_nxt = match_r + MC_W'(1);
               end else if (fr_has_e && !fr_bad_e) begin
                  cand_nxt  = fr_w_e;
                  match_nxt = MC_W'(1);
               end else begin
                  match_nxt = {MC_W{1'b0}};
               end
               if (match_nxt >= LOCK_V) state_nxt = LOCKED;
               else                     state_nxt = MEASURE;
            end else begin
               state_nxt = MEASURE;
            end
         end
         LOCKED: begin
            if (line_acc_s && (x_cnt_r != cand_r)) begin
               err_s     = 1'b1;
               match_nxt = {MC_W{1'b0}};
               // a frame start in the same cycle goes straight back to measuring
               if (vs_rise_s) state_nxt = MEASURE;
               else           state_nxt = ERR;
            end else begin
               state_nxt = LOCKED;
            end
         end
         ERR: begin
            if (vs_rise_s) begin
               state_nxt = MEASURE;
               match_nxt = {MC_W{1'b0}};
            end else begin
               state_nxt = ERR;
            end
         end
         default: begin
            state_nxt = IDLE;
            match_nxt = {MC_W{1'b0}};
         end
      endcase
   end

   assign lock_nxt = (state_nxt == LOCKED);
   assign h_load_s = (state_r != LOCKED) & lock_nxt;

   // Next pixel coordinates and window qualifier, aligned to the registered de
   always_comb begin
      x_nxt = x_pos;
      y_nxt = y_pos;
      if (de) begin
         if (de_d1_r) x_nxt = sat_inc(x_pos);
         else         x_nxt = {W_BITS{1'b0}};
      end else begin
         x_nxt = x_pos;
      end
      if (vs_rise_s)       y_nxt = {W_BITS{1'b0}};
      else if (line_acc_s) y_nxt = sat_inc(y_pos);
      else                 y_nxt = y_pos;
`ifdef BORDER_MASK_EN
      win_nxt = de & lock_nxt & (x_nxt >= W_BITS'(2)) & (y_nxt >= W_BITS'(2));
`else
      win_nxt = de & lock_nxt;
`endif
   end

   // Input pipeline, width counter, frame tracking and FSM state
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         de_d1_r  <= 1'b0;
         de_d2_r  <= 1'b0;
         vs_d1_r  <= 1'b0;
         vs_d2_r  <= 1'b0;
         x_cnt_r  <= {W_BITS{1'b0}};
         fr_has_r <= 1'b0;
         fr_bad_r <= 1'b0;
         fr_w_r   <= {W_BITS{1'b0}};
         match_r  <= {MC_W{1'b0}};
         cand_r   <= {W_BITS{1'b0}};
         state_r  <= IDLE;
      end else begin
         de_d1_r <= de;
         de_d2_r <= de_d1_r;
         vs_d1_r <= vsync;
         vs_d2_r <= vs_d1_r;
         if (de_d1_r) begin
            x_cnt_r <= de_d2_r ? sat_inc(x_cnt_r) : W_BITS'(1);
         end
         if (vs_rise_s) begin
            fr_has_r <= 1'b0;
            fr_bad_r <= 1'b0;
            fr_w_r   <= {W_BITS{1'b0}};
         end else begin
            fr_has_r <= fr_has_e;
            fr_bad_r <= fr_bad_e;
            fr_w_r   <= fr_w_e;
         end
         match_r <= match_nxt;
         cand_r  <= cand_nxt;
         state_r <= state_nxt;
      end
   end

   // Registered outputs; h_size only loads on entry to LOCKED
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         h_size     <= {W_BITS{1'b0}};
         ce         <= 1'b0;
         locked     <= 1'b0;
         frame_err  <= 1'b0;
         line_width <= {W_BITS{1'b0}};
         x_pos      <= {W_BITS{1'b0}};
         y_pos      <= {W_BITS{1'b0}};
         win_valid  <= 1'b0;
      end else begin
         if (h_load_s) h_size <= cand_nxt - DL_OFF_V;
         ce        <= lock_nxt;
         locked    <= lock_nxt;
         frame_err <= err_s;
         if (line_acc_s) line_width <= x_cnt_r;
         x_pos     <= x_nxt;
         y_pos     <= y_nxt;
         win_valid <= win_nxt;
      end
   end

endmodule

// File: tb/tb_sobel_timing_ctrl.sv
// Directed self-checking bench for sobel_timing_ctrl (lock, error, short lines, window count, reset, coincident edges, saturation).
module tb_sobel_timing_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, de, hsync, vsync;
   logic [10:0] h_size, line_width, x_pos, y_pos;
   logic        ce, locked, frame_err, win_valid;

   int n_tests = 0;
   int n_fail  = 0;
   int err_cycles = 0;
   int wv_cnt = 0;

`ifdef BORDER_MASK_EN
   localparam int EXP_WV = 28;
`else
   localparam int EXP_WV = 64;
`endif

   sobel_timing_ctrl dut (
      .clk(clk), .rst_n(rst_n), .de(de), .hsync(hsync), .vsync(vsync),
      .h_size(h_size), .ce(ce), .locked(locked), .frame_err(frame_err),
      .line_width(line_width), .x_pos(x_pos), .y_pos(y_pos), .win_valid(win_valid)
   );

   always #5 clk = ~clk;

   // Count high cycles of the pulse-type outputs, sampled on the falling edge
   always @(negedge clk) begin
      if (frame_err === 1'b1) err_cycles <= err_cycles + 1;
      if (win_valid === 1'b1) wv_cnt <= wv_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_line(input int w);
      for (int i = 0; i < w; i++) begin
         de = 1'b1;
         tick();
      end
      de = 1'b0;
      hsync = 1'b1;
      tick(); tick();
      hsync = 1'b0;
      tick(); tick();
   endtask

   task automatic vs_pulse();
      vsync = 1'b1;
      repeat (3) tick();
      vsync = 1'b0;
      repeat (3) tick();
   endtask

   task automatic send_frame(input int n, input int w);
      vs_pulse();
      repeat (n) send_line(w);
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %0b exp 0", locked); end
      n_tests++; if (ce !== 1'b0) begin n_fail++; $display("FAIL rst_ce: got %0b exp 0", ce); end
      n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err: got %0b exp 0", frame_err); end
      n_tests++; if (h_size !== 11'd0) begin n_fail++; $display("FAIL rst_h_size: got %0d exp 0", h_size); end
      n_tests++; if (line_width !== 11'd0) begin n_fail++; $display("FAIL rst_line_width: got %0d exp 0", line_width); end
      n_tests++; if (x_pos !== 11'd0 || y_pos !== 11'd0) begin n_fail++; $display("FAIL rst_pos: got x=%0d y=%0d exp 0", x_pos, y_pos); end
      n_tests++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL rst_win_valid: got %0b exp 0", win_valid); end
   endtask

   task automatic test_lock();
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      send_frame(4, 16);
      send_frame(4, 16);
      n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %0b exp 0", locked); end
      vsync = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_1clk: got %0b exp 0", locked); end
      @(negedge clk);
      n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_2clk: got %0b exp 1", locked); end
      n_tests++; if (ce !== 1'b1) begin n_fail++; $display("FAIL lock_ce: got %0b exp 1", ce); end
      tick(); tick();
      vsync = 1'b0;
      repeat (3) tick();
      n_tests++; if (h_size !== 11'd13) begin n_fail++; $display("FAIL lock_h_size: got %0d exp 13", h_size); end
      n_tests++; if (line_width !== 11'd16) begin n_fail++; $display("FAIL lock_line_width: got %0d exp 16", line_width); end
      repeat (4) send_line(16);
      n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_hold: got %0b exp 1", locked); end
   endtask

   task automatic test_win_valid();
      int wv0, e0;
      wv0 = wv_cnt;
      e0  = err_cycles;
      send_frame(4, 16);
      n_tests++; if (wv_cnt - wv0 != EXP_WV) begin n_fail++; $display("FAIL win_count: got %0d exp %0d", wv_cnt - wv0, EXP_WV); end
      n_tests++; if (y_pos !== 11'd4) begin n_fail++; $display("FAIL win_y_pos: got %0d exp 4", y_pos); end
      n_tests++; if (x_pos !== 11'd15) begin n_fail++; $display("FAIL win_x_pos: got %0d exp 15", x_pos); end
      n_tests++; if (err_cycles != e0) begin n_fail++; $display("FAIL win_no_err: got %0d exp %0d", err_cycles, e0); end
   endtask

   task automatic test_short_line();
      int e0;
      e0 = err_cycles;
      vs_pulse();
      send_line(16);
      send_line(16);
      n_tests++; if (y_pos !== 11'd2) begin n_fail++; $display("FAIL short_y_before: got %0d exp 2", y_pos); end
      send_line(5);
      send_line(7);
      n_tests++; if (y_pos !== 11'd2) begin n_fail++; $display("FAIL short_y_after: got %0d exp 2", y_pos); end
      n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL short_locked: got %0b exp 1", locked); end
      n_tests++; if (line_width !== 11'd16) begin n_fail++; $display("FAIL short_line_width: got %0d exp 16", line_width); end
      send_line(16);
      send_line(16);
      n_tests++; if (y_pos !== 11'd4) begin n_fail++; $display("FAIL short_y_end: got %0d exp 4", y_pos); end
      n_tests++; if (err_cycles != e0) begin n_fail++; $display("FAIL short_no_err: got %0d exp %0d", err_cycles, e0); end
   endtask

   task automatic test_err();
      int e0;
      e0 = err_cycles;
      vs_pulse();
      send_line(16);
      send_line(15);
      n_tests++; if (err_cycles - e0 != 1) begin n_fail++; $display("FAIL err_pulse: got %0d cycles exp 1", err_cycles - e0); end
      n_tests++; if (locked !== 1'b0 || ce !== 1'b0) begin n_fail++; $display("FAIL err_unlock: got locked=%0b ce=%0b exp 0", locked, ce); end
      n_tests++; if (h_size !== 11'd13) begin n_fail++; $display("FAIL err_h_size_hold: got %0d exp 13", h_size); end
      n_tests++; if (line_width !== 11'd15) begin n_fail++; $display("FAIL err_line_width: got %0d exp 15", line_width); end
      send_line(16);
      send_line(16);
      send_frame(4, 16);
      send_frame(4, 16);
      n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL err_relock_early: got %0b exp 0", locked); end
      vs_pulse();
      n_tests++; if (locked !== 1'b1 || ce !== 1'b1) begin n_fail++; $display("FAIL err_relock: got locked=%0b ce=%0b exp 1", locked, ce); end
      n_tests++; if (h_size !== 11'd13) begin n_fail++; $display("FAIL err_relock_h_size: got %0d exp 13", h_size); end
      n_tests++; if (err_cycles - e0 != 1) begin n_fail++; $display("FAIL err_single: got %0d cycles exp 1", err_cycles - e0); end
   endtask

   task automatic test_reset_mid();
      vs_pulse();
      de = 1'b1;
      repeat (5) tick();
      n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_locked: got %0b exp 1", locked); end
      rst_n = 1'b0;
      #1;
      n_tests++; if (locked !== 1'b0 || ce !== 1'b0 || frame_err !== 1'b0 || win_valid !== 1'b0) begin
         n_fail++; $display("FAIL rmid_flags: got locked=%0b ce=%0b err=%0b wv=%0b exp 0", locked, ce, frame_err, win_valid); end
      n_tests++; if (h_size !== 11'd0 || line_width !== 11'd0) begin
         n_fail++; $display("FAIL rmid_widths: got h_size=%0d line_width=%0d exp 0", h_size, line_width); end
      n_tests++; if (x_pos !== 11'd0 || y_pos !== 11'd0) begin n_fail++; $display("FAIL rmid_pos: got x=%0d y=%0d exp 0", x_pos, y_pos); end
      de = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      send_frame(4, 16);
      send_frame(4, 16);
      n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rmid_early: got %0b exp 0", locked); end
      vs_pulse();
      n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rmid_relock: got %0b exp 1", locked); end
      n_tests++; if (h_size !== 11'd13) begin n_fail++; $display("FAIL rmid_h_size: got %0d exp 13", h_size); end
   endtask

   task automatic test_coincident();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      vs_pulse();
      // single line whose de fall meets the next vsync rise; it must count in the ending frame
      for (int i = 0; i < 16; i++) begin de = 1'b1; tick(); end
      de = 1'b0; vsync = 1'b1;
      repeat (3) tick();
      vsync = 1'b0;
      repeat (3) tick();
      repeat (3) send_line(16);
      for (int i = 0; i < 16; i++) begin de = 1'b1; tick(); end
      de = 1'b0; vsync = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL coin_1clk: got %0b exp 0", locked); end
      @(negedge clk);
      n_tests++; if (locked !== 1'b1 || ce !== 1'b1) begin n_fail++; $display("FAIL coin_2clk: got locked=%0b ce=%0b exp 1", locked, ce); end
      tick(); tick();
      vsync = 1'b0;
      repeat (3) tick();
      n_tests++; if (h_size !== 11'd13) begin n_fail++; $display("FAIL coin_h_size: got %0d exp 13", h_size); end
      n_tests++; if (line_width !== 11'd16) begin n_fail++; $display("FAIL coin_line_width: got %0d exp 16", line_width); end
   endtask

   task automatic test_saturate();
      int e0;
      e0 = err_cycles;
      vs_pulse();
      send_line(2100);
      n_tests++; if (err_cycles - e0 != 1) begin n_fail++; $display("FAIL sat_err: got %0d cycles exp 1", err_cycles - e0); end
      n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL sat_unlock: got %0b exp 0", locked); end
      n_tests++; if (line_width !== 11'd2047) begin n_fail++; $display("FAIL sat_line_width: got %0d exp 2047", line_width); end
      n_tests++; if (x_pos !== 11'd2047) begin n_fail++; $display("FAIL sat_x_pos: got %0d exp 2047", x_pos); end
      n_tests++; if (y_pos !== 11'd1) begin n_fail++; $display("FAIL sat_y_pos: got %0d exp 1", y_pos); end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_win_valid();
      test_short_line();
      test_err();
      test_reset_mid();
      test_coincident();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
      $fatal(1, "time limit reached");
   end

endmodule
